// File: rtl/flex_counter_pkg.sv
// Shared types and defaults for the flex counter family.
package flex_counter_pkg;

  typedef enum logic [0:0] {
    CNT_IDLE = 1'b0,
    CNT_RUN  = 1'b1
  } cnt_state_t;

  localparam int unsigned DEFAULT_NUM_CNT_BITS = 4;

endpackage

// File: rtl/flex_down_counter.sv
// Loadable down-counter with a one-cycle terminal-count pulse and optional auto-reload.
// Define FLEX_DOWN_COUNTER_OVERRUN_EN to build the sticky restart-while-busy flag.
module flex_down_counter
  import flex_counter_pkg::*;
#(
  parameter int unsigned NUM_CNT_BITS = DEFAULT_NUM_CNT_BITS
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic                    count_enable,
  input  logic                    auto_reload,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    zero_flag,
  output logic                    busy,
  output logic                    overrun
);

  cnt_state_t              state_q, state_d;
  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  logic [NUM_CNT_BITS-1:0] reload_q, reload_d;
  logic                    zero_q, zero_d;
  logic                    running;
  logic                    terminal;

  assign running  = (state_q == CNT_RUN);
  assign terminal = running && count_enable && (count_q == NUM_CNT_BITS'(1));

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    zero_d   = 1'b0;
    if (clear) begin
      state_d  = CNT_IDLE;
      count_d  = '0;
      reload_d = '0;
    end else if (load) begin
      if (load_val != '0) begin
        state_d  = CNT_RUN;
        count_d  = load_val;
        reload_d = load_val;
      end else if (running) begin
        // A zero load while running aborts the countdown without a pulse.
        state_d = CNT_IDLE;
        count_d = '0;
      end
    end else if (terminal) begin
      zero_d = 1'b1;
      if (auto_reload) begin
        count_d = reload_q;
      end else begin
        state_d = CNT_IDLE;
        count_d = '0;
      end
    end else if (running && count_enable) begin
      count_d = count_q - NUM_CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= CNT_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      zero_q   <= zero_d;
    end
  end

  assign count_out = count_q;
  assign zero_flag = zero_q;
  assign busy      = running;

`ifdef FLEX_DOWN_COUNTER_OVERRUN_EN
  logic overrun_q, overrun_d;

  // A load that coincides with a terminal decrement is not counted as an overrun.
  always_comb begin
    overrun_d = overrun_q;
    if (clear) begin
      overrun_d = 1'b0;
    end else if (load && running && !(count_enable && count_q == NUM_CNT_BITS'(1))) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

endmodule
